ctrl_frame_tx_engine: RTL and testbench

Parametrised control-frame transmitter on the picosoc iomem bus. Firmware fills a frame buffer, programs a byte length and a port mask, then starts transmission. The block acquires the per-port PHY-TX FIFO mutex and streams bytes into the selected FIFOs, with per-byte afull throttling, mid-frame abort and a completion interrupt.

---
 rtl/ctrl_frame_tx_engine_if.sv | 22 ++
 rtl/ctrl_frame_tx_engine.sv | 229 ++++++++++++++++++++++
 tb/tb_ctrl_frame_tx_engine.sv | 318 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ctrl_frame_tx_engine_if.sv
`default_nettype none
// ctrl_frame_tx_engine_if: picosoc iomem bus bundle (master = CPU side, slave = peripheral side).
// Rev 1.0
interface ctrl_frame_tx_engine_if;
  logic        iomem_valid;
  logic        iomem_ready;
  logic [3:0]  iomem_wstrb;
  logic [31:0] iomem_addr;
  logic [31:0] iomem_wdata;
  logic [31:0] iomem_rdata;

  modport master (
    output iomem_valid, iomem_wstrb, iomem_addr, iomem_wdata,
    input  iomem_ready, iomem_rdata
  );

  modport slave (
    input  iomem_valid, iomem_wstrb, iomem_addr, iomem_wdata,
    output iomem_ready, iomem_rdata
  );
endinterface
`default_nettype wire

// File: rtl/ctrl_frame_tx_engine.sv
`default_nettype none
// ctrl_frame_tx_engine: iomem-mapped frame buffer streamed into mutex-guarded PHY-TX FIFOs.
// Rev 1.0
module ctrl_frame_tx_engine #(
  parameter int         NUM_PORTS = 4,
  parameter int         RAM_WORDS = 64,
  parameter logic [7:0] CFG_SEL   = 8'h15,
  parameter logic [7:0] RAM_SEL   = 8'h05
) (
  input  wire logic                 clk,
  input  wire logic                 arst_n,
  ctrl_frame_tx_engine_if.slave     bus,
  output logic [7:0]                o_fifo_din,
  output logic                      o_fifo_del,
  input  wire logic [NUM_PORTS-1:0] fifo_afull,
  output logic [NUM_PORTS-1:0]      fifo_wren,
  output logic [NUM_PORTS-1:0]      mutex_req,
  input  wire logic [NUM_PORTS-1:0] mutex_val,
  output logic                      irq
);
  localparam int          AW      = $clog2(RAM_WORDS);
  localparam logic [31:0] MAX_LEN = 32'(4 * RAM_WORDS);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_TX   = 2'd2,
    S_END  = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic                 ready_q, ready_d;
  logic [31:0]          rdata_q, rdata_d;
  logic [7:0]           din_q, din_d;
  logic                 del_q, del_d;
  logic [NUM_PORTS-1:0] wren_q, wren_d, mreq_q, mreq_d;
  logic [NUM_PORTS-1:0] port_q, port_d, lport_q, lport_d;
  logic [15:0]          len_q, len_d, llen_q, llen_d, cnt_q, cnt_d;
  logic                 irq_en_q, irq_en_d, done_q, done_d;
  logic                 aborted_q, aborted_d, err_q, err_d;
  logic                 abort_pend_q, abort_pend_d, abort_taken_q, abort_taken_d;
  logic [31:0]          mem_q [RAM_WORDS];

  logic          cfg_hit, ram_hit, acc, cfg_wr, ram_wr, start_w, abort_w;
  logic          afull_hit, tx_last, last_out;
  logic [1:0]    off;
  logic [AW-1:0] widx;
  logic [31:0]   tx_word, status;
  logic [7:0]    tx_byte;
  logic          unused_addr;

  assign cfg_hit   = (bus.iomem_addr[31:24] == CFG_SEL);
  assign ram_hit   = (bus.iomem_addr[31:24] == RAM_SEL);
  assign off       = bus.iomem_addr[3:2];
  assign widx      = bus.iomem_addr[AW+1:2];
  // Writes commit during the ready cycle, while the master still holds the access.
  assign acc       = ready_q && bus.iomem_valid;
  assign cfg_wr    = acc && cfg_hit && (bus.iomem_wstrb != 4'b0000);
  assign ram_wr    = acc && ram_hit && (bus.iomem_wstrb != 4'b0000) && (state_q == S_IDLE);
  assign start_w   = cfg_wr && (off == 2'd0) && bus.iomem_wstrb[3] && bus.iomem_wdata[31];
  assign abort_w   = cfg_wr && (off == 2'd0) && bus.iomem_wstrb[3] && bus.iomem_wdata[28];
  assign tx_word   = mem_q[cnt_q[AW+1:2]];
  assign tx_byte   = tx_word[{cnt_q[1:0], 3'b000} +: 8];
  assign afull_hit = |(fifo_afull & lport_q);
  assign tx_last   = abort_pend_q || (cnt_q == llen_q - 16'd1);
  assign last_out  = wren_q[0] | (|wren_q) ? del_q : 1'b0;
  assign status    = {1'b0, state_q == S_IDLE, state_q != S_IDLE, 1'b0,
                      done_q, aborted_q, err_q, irq_en_q, 24'd0};
  assign unused_addr = ^{bus.iomem_addr[23:AW+2], bus.iomem_addr[1:0]};

  always_comb begin
    state_d       = state_q;
    ready_d       = 1'b0;
    rdata_d       = 32'd0;
    din_d         = din_q;
    del_d         = 1'b0;
    wren_d        = '0;
    mreq_d        = mreq_q;
    port_d        = port_q;
    len_d         = len_q;
    lport_d       = lport_q;
    llen_d        = llen_q;
    cnt_d         = cnt_q;
    irq_en_d      = irq_en_q;
    done_d        = done_q;
    aborted_d     = aborted_q;
    err_d         = err_q;
    abort_pend_d  = abort_pend_q;
    abort_taken_d = abort_taken_q;

    if (bus.iomem_valid && (cfg_hit || ram_hit) && !ready_q) begin
      ready_d = 1'b1;
      if (ram_hit) begin
        rdata_d = mem_q[widx];
      end else begin
        case (off)
          2'd0:    rdata_d = status;
          2'd1:    rdata_d = {{(32-NUM_PORTS){1'b0}}, port_q};
          2'd2:    rdata_d = {16'd0, len_q};
          default: rdata_d = 32'd0;
        endcase
      end
    end

    if (cfg_wr) begin
      case (off)
        2'd0: if (bus.iomem_wstrb[3]) begin
          irq_en_d = bus.iomem_wdata[24];
          if (bus.iomem_wdata[27]) done_d    = 1'b0;
          if (bus.iomem_wdata[26]) aborted_d = 1'b0;
          if (bus.iomem_wdata[25]) err_d     = 1'b0;
        end
        2'd1: if (bus.iomem_wstrb[0]) port_d = bus.iomem_wdata[NUM_PORTS-1:0];
        2'd2: begin
          if (bus.iomem_wstrb[0]) len_d[7:0]  = bus.iomem_wdata[7:0];
          if (bus.iomem_wstrb[1]) len_d[15:8] = bus.iomem_wdata[15:8];
        end
        default: ;
      endcase
    end

    case (state_q)
      S_IDLE: if (start_w) begin
        if ((len_q == 16'd0) || ({16'd0, len_q} > MAX_LEN) || (port_q == '0)) begin
          err_d = 1'b1;
        end else begin
          lport_d       = port_q;
          llen_d        = len_q;
          mreq_d        = port_q;
          cnt_d         = 16'd0;
          abort_pend_d  = 1'b0;
          abort_taken_d = 1'b0;
          state_d       = S_WAIT;
        end
      end
      S_WAIT: begin
        if (abort_w) begin
          abort_taken_d = 1'b1;
          state_d       = S_END;
        end else if ((mutex_val & lport_q) == lport_q) begin
          state_d = S_TX;
        end
      end
      S_TX: begin
        // Once the del byte is on the outputs the frame is closed; a late abort is moot.
        if (abort_w && !last_out) begin
          abort_pend_d  = 1'b1;
          abort_taken_d = 1'b1;
        end
        if (last_out) begin
          state_d = S_END;
        end else if (!afull_hit) begin
          wren_d = lport_q;
          din_d  = tx_byte;
          del_d  = tx_last;
          cnt_d  = cnt_q + 16'd1;
        end
      end
      S_END: begin
        mreq_d       = '0;
        cnt_d        = 16'd0;
        abort_pend_d = 1'b0;
        if (abort_taken_q) aborted_d = 1'b1;
        else               done_d    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q       <= S_IDLE;
      ready_q       <= 1'b0;
      rdata_q       <= 32'd0;
      din_q         <= 8'd0;
      del_q         <= 1'b0;
      wren_q        <= '0;
      mreq_q        <= '0;
      port_q        <= '0;
      len_q         <= 16'd0;
      lport_q       <= '0;
      llen_q        <= 16'd0;
      cnt_q         <= 16'd0;
      irq_en_q      <= 1'b0;
      done_q        <= 1'b0;
      aborted_q     <= 1'b0;
      err_q         <= 1'b0;
      abort_pend_q  <= 1'b0;
      abort_taken_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      ready_q       <= ready_d;
      rdata_q       <= rdata_d;
      din_q         <= din_d;
      del_q         <= del_d;
      wren_q        <= wren_d;
      mreq_q        <= mreq_d;
      port_q        <= port_d;
      len_q         <= len_d;
      lport_q       <= lport_d;
      llen_q        <= llen_d;
      cnt_q         <= cnt_d;
      irq_en_q      <= irq_en_d;
      done_q        <= done_d;
      aborted_q     <= aborted_d;
      err_q         <= err_d;
      abort_pend_q  <= abort_pend_d;
      abort_taken_q <= abort_taken_d;
    end
  end

  always_ff @(posedge clk) begin
    if (ram_wr) begin
      for (int b = 0; b < 4; b++) begin
        if (bus.iomem_wstrb[b]) mem_q[widx][8*b +: 8] <= bus.iomem_wdata[8*b +: 8];
      end
    end
  end

  assign bus.iomem_ready = ready_q;
  assign bus.iomem_rdata = rdata_q;
  assign o_fifo_din      = din_q;
  assign o_fifo_del      = del_q;
  assign fifo_wren       = wren_q;
  assign mutex_req       = mreq_q;
  assign irq             = done_q & irq_en_q;
endmodule
`default_nettype wire

// File: tb/tb_ctrl_frame_tx_engine.sv
`timescale 1ns/1ps
`default_nettype none
// tb_ctrl_frame_tx_engine: directed + randomized frames checked against a byte-stream model.
// Rev 1.0
module tb_ctrl_frame_tx_engine;
  localparam int          NUM_PORTS = 4;
  localparam int          RAM_WORDS = 64;
  localparam int          MAX_LEN   = 4 * RAM_WORDS;
  localparam logic [31:0] A_CTRL    = 32'h1500_0000;
  localparam logic [31:0] A_PORT    = 32'h1500_0004;
  localparam logic [31:0] A_LEN     = 32'h1500_0008;
  localparam logic [31:0] RAM_BASE  = 32'h0500_0000;

  logic                 clk = 1'b0;
  logic                 arst_n = 1'b0;
  logic [NUM_PORTS-1:0] fifo_afull = '0;
  logic [NUM_PORTS-1:0] mutex_val = '0;
  logic [NUM_PORTS-1:0] fifo_wren, mutex_req;
  logic [7:0]           o_fifo_din;
  logic                 o_fifo_del, irq;

  ctrl_frame_tx_engine_if bus();

  ctrl_frame_tx_engine #(
    .NUM_PORTS(NUM_PORTS), .RAM_WORDS(RAM_WORDS), .CFG_SEL(8'h15), .RAM_SEL(8'h05)
  ) dut (
    .clk(clk), .arst_n(arst_n), .bus(bus),
    .o_fifo_din(o_fifo_din), .o_fifo_del(o_fifo_del),
    .fifo_afull(fifo_afull), .fifo_wren(fifo_wren),
    .mutex_req(mutex_req), .mutex_val(mutex_val), .irq(irq)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int viol = 0;
  int mreq_fall = -1;
  logic [NUM_PORTS-1:0] mreq_prev = '0;
  logic [NUM_PORTS+8:0] cap_q[$];
  int                   cap_cyc[$];
  logic [31:0]          ram_img [RAM_WORDS];

  always @(posedge clk) cyc++;

  // Byte capture on the FIFO side, plus afull-obedience bookkeeping.
  always @(negedge clk) begin
    if (arst_n) begin
      if (fifo_wren != '0) begin
        cap_q.push_back({fifo_wren, o_fifo_del, o_fifo_din});
        cap_cyc.push_back(cyc);
        if ((fifo_wren & fifo_afull) != '0) viol++;
      end
      if (mreq_prev != '0 && mutex_req == '0) mreq_fall = cyc;
      mreq_prev = mutex_req;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] exp_byte(input int n);
    logic [31:0] w;
    w = ram_img[n / 4] >> (8 * (n % 4));
    return w[7:0];
  endfunction

  function automatic logic [NUM_PORTS-1:0] rnd_afull();
    logic [NUM_PORTS-1:0] v;
    for (int b = 0; b < NUM_PORTS; b++) v[b] = ($urandom_range(0, 3) == 0);
    return v;
  endfunction

  task automatic bus_access(input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input bit exp_ready,
                            output logic [31:0] rdata);
    bit got = 0;
    rdata = 32'd0;
    @(posedge clk); #1;
    bus.iomem_valid = 1'b1;
    bus.iomem_addr  = addr;
    bus.iomem_wdata = data;
    bus.iomem_wstrb = strb;
    for (int i = 0; i < 8 && !got; i++) begin
      @(negedge clk);
      if (bus.iomem_ready) begin
        got   = 1;
        rdata = bus.iomem_rdata;
      end
    end
    chk("bus_ready", 32'(got), 32'(exp_ready));
    @(posedge clk); #1;
    bus.iomem_valid = 1'b0;
    bus.iomem_wstrb = 4'b0000;
    @(negedge clk);
    if (got) chk("ready_single_pulse", 32'(bus.iomem_ready), 32'd0);
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data);
    logic [31:0] dummy;
    bus_access(addr, data, 4'hF, 1'b1, dummy);
  endtask

  task automatic rd_chk(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    logic [31:0] v;
    bus_access(addr, 32'd0, 4'h0, 1'b1, v);
    chk(tag, v, exp);
  endtask

  task automatic clear_cap();
    cap_q.delete();
    cap_cyc.delete();
    viol      = 0;
    mreq_fall = -1;
  endtask

  task automatic run_until_idle(input int budget, input bit rnd);
    bit idle = 0;
    for (int i = 0; i < budget && !idle; i++) begin
      @(negedge clk); #1;
      if (mutex_req == '0) idle = 1;
      else if (rnd) fifo_afull = rnd_afull();
    end
    fifo_afull = '0;
    chk("frame_end_in_budget", 32'(idle), 32'd1);
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_bytes(input int n);
    bit hit = 0;
    for (int i = 0; i < 500 && !hit; i++) begin
      @(negedge clk); #1;
      if (cap_q.size() >= n) hit = 1;
    end
    chk("bytes_reached", 32'(hit), 32'd1);
  endtask

  task automatic check_frame(input string tag, input logic [NUM_PORTS-1:0] port, input int n);
    chk({tag, "_count"}, 32'(cap_q.size()), 32'(n));
    for (int i = 0; i < cap_q.size() && i < n; i++)
      chk({tag, "_byte"}, 32'(cap_q[i]), 32'({port, (i == n - 1), exp_byte(i)}));
    chk({tag, "_afull_obeyed"}, 32'(viol), 32'd0);
  endtask

  initial begin
    logic [NUM_PORTS-1:0] port;
    int                   len;
    logic [31:0]          dummy;
    bus.iomem_valid = 1'b0;
    bus.iomem_addr  = 32'd0;
    bus.iomem_wdata = 32'd0;
    bus.iomem_wstrb = 4'd0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_rdata", bus.iomem_rdata, 32'd0);
    chk("rst_outputs", 32'({bus.iomem_ready, fifo_wren, o_fifo_din, o_fifo_del, mutex_req, irq}), 32'd0);
    @(posedge clk); #1 arst_n = 1'b1;
    rd_chk("rst_status", A_CTRL, 32'h4000_0000);
    rd_chk("rst_len", A_LEN, 32'd0);
    bus_access(32'h2000_0000, 32'd0, 4'h0, 1'b0, dummy);

    // Counting-pattern frame on ports 0 and 2, immediate grant
    for (int w = 0; w < 16; w++) begin
      ram_img[w] = {8'(4*w+3), 8'(4*w+2), 8'(4*w+1), 8'(4*w)};
      wr(RAM_BASE + 32'(4*w), ram_img[w]);
    end
    rd_chk("ram_readback", RAM_BASE + 32'd12, 32'h0F0E_0D0C);
    clear_cap();
    mutex_val = '1;
    wr(A_PORT, 32'h5);
    wr(A_LEN, 32'd64);
    wr(A_CTRL, 32'h8100_0000);
    run_until_idle(1000, 1'b0);
    check_frame("count64", 4'b0101, 64);
    if (cap_cyc.size() == 64) begin
      chk("count64_consecutive", 32'(cap_cyc[63] - cap_cyc[0]), 32'd63);
      chk("count64_mutex_release", 32'(mreq_fall - cap_cyc[63]), 32'd2);
    end
    chk("count64_irq", 32'(irq), 32'd1);
    rd_chk("count64_status", A_CTRL, 32'h4900_0000);
    wr(A_CTRL, 32'h0E00_0000);
    chk("irq_cleared", 32'(irq), 32'd0);

    // Short frame throttled by afull for 3 cycles
    clear_cap();
    wr(A_PORT, 32'h2);
    wr(A_LEN, 32'd5);
    wr(A_CTRL, 32'h8000_0000);
    wait_bytes(2);
    fifo_afull = 4'b0010;
    repeat (3) begin @(negedge clk); #1; end
    fifo_afull = '0;
    run_until_idle(200, 1'b0);
    check_frame("throttle5", 4'b0010, 5);
    if (cap_cyc.size() >= 3) chk("throttle5_gap", 32'(cap_cyc[2] - cap_cyc[1]), 32'd4);
    rd_chk("throttle5_status", A_CTRL, 32'h4800_0000);
    wr(A_CTRL, 32'h0E00_0000);

    // Randomized frames: random content, length, ports, grant delay and afull
    for (int it = 0; it < 6; it++) begin
      for (int w = 0; w < RAM_WORDS; w++) begin
        ram_img[w] = $urandom;
        wr(RAM_BASE + 32'(4*w), ram_img[w]);
      end
      len  = (it == 0) ? MAX_LEN : (it == 1) ? 1 : int'($urandom_range(2, MAX_LEN - 1));
      port = NUM_PORTS'($urandom_range(1, (1 << NUM_PORTS) - 1));
      clear_cap();
      mutex_val = '0;
      wr(A_PORT, 32'(port));
      wr(A_LEN, 32'(len));
      wr(A_CTRL, 32'h8000_0000);
      repeat ($urandom_range(1, 5)) @(negedge clk);
      chk("rand_wait_req", 32'(mutex_req), 32'(port));
      chk("rand_wait_no_wren", 32'(cap_q.size()), 32'd0);
      mutex_val = '1;
      run_until_idle(5000, 1'b1);
      check_frame("rand", port, len);
      rd_chk("rand_status", A_CTRL, 32'h4800_0000);
      wr(A_CTRL, 32'h0E00_0000);
    end

    // Grant withheld, then abort while waiting
    clear_cap();
    mutex_val = '0;
    wr(A_PORT, 32'h8);
    wr(A_LEN, 32'd16);
    wr(A_CTRL, 32'h8000_0000);
    repeat (10) @(negedge clk);
    mutex_val = 4'b0111;
    repeat (10) @(negedge clk);
    chk("wait_req", 32'(mutex_req), 32'h8);
    chk("wait_no_wren", 32'(cap_q.size()), 32'd0);
    wr(A_CTRL, 32'h1000_0000);
    run_until_idle(50, 1'b0);
    chk("wait_abort_bytes", 32'(cap_q.size()), 32'd0);
    chk("wait_abort_req", 32'(mutex_req), 32'd0);
    rd_chk("wait_abort_status", A_CTRL, 32'h4400_0000);
    wr(A_CTRL, 32'h0E00_0000);

    // Abort after byte 10 of a 64-byte frame
    clear_cap();
    mutex_val = '1;
    wr(A_PORT, 32'h1);
    wr(A_LEN, 32'd64);
    wr(A_CTRL, 32'h8000_0000);
    wait_bytes(11);
    fifo_afull = 4'b0001;
    wr(A_CTRL, 32'h1000_0000);
    chk("abort_stalled_count", 32'(cap_q.size()), 32'd11);
    fifo_afull = '0;
    run_until_idle(200, 1'b0);
    check_frame("abort12", 4'b0001, 12);
    chk("abort12_req", 32'(mutex_req), 32'd0);
    rd_chk("abort12_status", A_CTRL, 32'h4400_0000);
    wr(A_CTRL, 32'h0E00_0000);

    // Invalid starts set err and leave the block idle
    wr(A_PORT, 32'h1);
    wr(A_LEN, 32'd0);
    wr(A_CTRL, 32'h8000_0000);
    chk("err_len0_req", 32'(mutex_req), 32'd0);
    rd_chk("err_len0_status", A_CTRL, 32'h4200_0000);
    wr(A_CTRL, 32'h0200_0000);
    rd_chk("err_w1c", A_CTRL, 32'h4000_0000);
    wr(A_LEN, 32'(MAX_LEN + 1));
    wr(A_CTRL, 32'h8000_0000);
    rd_chk("err_len_max_status", A_CTRL, 32'h4200_0000);
    wr(A_CTRL, 32'h0200_0000);
    wr(A_LEN, 32'd4);
    wr(A_PORT, 32'h0);
    wr(A_CTRL, 32'h8000_0000);
    rd_chk("err_port0_status", A_CTRL, 32'h4200_0000);
    wr(A_CTRL, 32'h0200_0000);

    // Buffer writes are dropped while busy
    mutex_val = '0;
    wr(A_PORT, 32'h1);
    wr(A_CTRL, 32'h8000_0000);
    wr(RAM_BASE, 32'hDEAD_BEEF);
    wr(A_CTRL, 32'h1000_0000);
    run_until_idle(50, 1'b0);
    rd_chk("busy_ram_unchanged", RAM_BASE, ram_img[0]);
    wr(A_CTRL, 32'h0E00_0000);

    // Asynchronous reset in the middle of a frame
    clear_cap();
    mutex_val = '1;
    wr(A_PORT, 32'hF);
    wr(A_LEN, 32'd200);
    wr(A_CTRL, 32'h8000_0000);
    wait_bytes(5);
    arst_n = 1'b0;
    #1;
    chk("midtx_rst_outputs", 32'({bus.iomem_ready, fifo_wren, o_fifo_del, mutex_req, irq}), 32'd0);
    chk("midtx_rst_din", 32'(o_fifo_din), 32'd0);
    repeat (2) @(negedge clk);
    @(posedge clk); #1 arst_n = 1'b1;
    rd_chk("midtx_rst_status", A_CTRL, 32'h4000_0000);
    rd_chk("midtx_rst_len", A_LEN, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
`default_nettype wire
